// File: rtl/ddr_port_arbiter_mister.sv
// Purpose: round-robin bridge from NUM_PORTS word requesters to a single-beat DDR3 Avalon-MM master.
// Latency: grant -> command next cycle; write done 2 cycles after grant, read ready 1 cycle after read data.
// Backpressure: DDRAM_BUSY holds the command and address/data stable; requesters hold their request until ready/done.
module ddr_port_arbiter_mister #(
    parameter int          NUM_PORTS = 2,
    parameter int          ADDR_W    = 22,
    parameter int          DATA_W    = 32,
    parameter logic [28:0] ADDR_BASE = 29'h0,
    parameter int          TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          DDRAM_CLK,
    input  logic                          DDRAM_BUSY,
    output logic [7:0]                    DDRAM_BURSTCNT,
    output logic [28:0]                   DDRAM_ADDR,
    input  logic [63:0]                   DDRAM_DOUT,
    input  logic                          DDRAM_DOUT_READY,
    output logic                          DDRAM_RD,
    output logic [63:0]                   DDRAM_DIN,
    output logic [7:0]                    DDRAM_BE,
    output logic                          DDRAM_WE,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [NUM_PORTS-1:0]          port_write,
    output logic [NUM_PORTS*DATA_W-1:0]   port_rdata,
    output logic [NUM_PORTS-1:0]          port_ready,
    output logic [NUM_PORTS-1:0]          port_done,
    output logic [NUM_PORTS-1:0]          port_timeout
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int EW = (ADDR_W > 29) ? ADDR_W : 29;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_RWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [PW-1:0]       last;
    logic [PW-1:0]       gnt;
    logic                op_rd;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [15:0]         cnt;
    logic [16:0]         cnt_inc;

    logic [NUM_PORTS-1:0] pend;
    logic                 found;
    logic [PW-1:0]        pick;
    logic [DATA_W-1:0]    rd_lane;
    logic [EW-1:0]        addr_ext;

    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;
    assign pend           = port_req | port_write;
    assign cnt_inc        = {1'b0, cnt} + 17'd1;
    assign addr_ext       = EW'(lat_addr);

    // Lane selection: 32-bit ports live in one half of the 64-bit beat, 64-bit ports use it whole.
    generate
        if (DATA_W == 32) begin : g_lane32
            logic [EW-1:0] beat;
            assign beat       = addr_ext >> 1;
            assign DDRAM_ADDR = ADDR_BASE + beat[28:0];
            assign DDRAM_BE   = lat_addr[0] ? 8'hF0 : 8'h0F;
            assign DDRAM_DIN  = {lat_wdata, lat_wdata};
            assign rd_lane    = lat_addr[0] ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
        end else begin : g_lane64
            assign DDRAM_ADDR = ADDR_BASE + addr_ext[28:0];
            assign DDRAM_BE   = 8'hFF;
            assign DDRAM_DIN  = lat_wdata;
            assign rd_lane    = DDRAM_DOUT[DATA_W-1:0];
        end
    endgenerate

    // Round-robin scan starting one past the last granted port.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Access sequencer: grant, issue command under waitrequest, await data or timeout, hold response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            last         <= PW'(NUM_PORTS - 1);
            gnt          <= '0;
            op_rd        <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cnt          <= '0;
            DDRAM_RD     <= 1'b0;
            DDRAM_WE     <= 1'b0;
            port_rdata   <= '1;
            port_ready   <= '0;
            port_done    <= '0;
            port_timeout <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt       <= pick;
                        last      <= pick;
                        lat_addr  <= port_addr[int'(pick)*ADDR_W +: ADDR_W];
                        lat_wdata <= port_wdata[int'(pick)*DATA_W +: DATA_W];
                        op_rd     <= port_req[pick];
                        DDRAM_RD  <= port_req[pick];
                        DDRAM_WE  <= !port_req[pick];
                        state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        DDRAM_WE <= 1'b0;
                        cnt      <= '0;
                        if (op_rd) begin
                            state <= S_RWAIT;
                        end else begin
                            port_done[gnt] <= 1'b1;
                            state          <= S_RESP;
                        end
                    end
                end
                S_RWAIT: begin
                    // Data arriving in the same cycle as the timeout still wins.
                    if (DDRAM_DOUT_READY) begin
                        port_rdata[int'(gnt)*DATA_W +: DATA_W] <= rd_lane;
                        port_timeout[gnt] <= 1'b0;
                        port_ready[gnt]   <= 1'b1;
                        cnt               <= '0;
                        state             <= S_RESP;
                    end else if (cnt_inc == 17'(TIMEOUT)) begin
                        port_rdata[int'(gnt)*DATA_W +: DATA_W] <= '1;
                        port_timeout[gnt] <= 1'b1;
                        port_ready[gnt]   <= 1'b1;
                        cnt               <= '0;
                        state             <= S_RESP;
                    end else begin
                        cnt <= cnt_inc[15:0];
                    end
                end
                S_RESP: begin
                    if (op_rd ? !port_req[gnt] : !port_write[gnt]) begin
                        port_ready[gnt] <= 1'b0;
                        port_done[gnt]  <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
